// File: rtl/lc3b_types.sv
// Shared LC-3b cache-hierarchy types: the cache line type, the L2 port
// arbiter state and owner encodings, and the two-way round-robin pick.
package lc3b_types;

    localparam int LINE_WIDTH = 128;

    typedef logic [LINE_WIDTH-1:0] lc3b_c_line;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    // A lone requester wins outright. When both sides ask, the side that did
    // not win last time wins, so neither fetch nor memory stage can starve.
    function automatic arb_owner_t rr_pick2(input logic req_i,
                                            input logic req_d,
                                            input arb_owner_t last);
        if (req_i && req_d) begin
            return (last == OWN_I) ? OWN_D : OWN_I;
        end else if (req_d) begin
            return OWN_D;
        end else begin
            return OWN_I;
        end
    endfunction

endpackage

// File: rtl/l2_port_arbiter.sv
// Shares the single L2 port between the I-cache miss path and the D-cache
// miss/writeback path. One transaction at a time: grant in IDLE, hold the
// latched request on the L2 strobes in BUSY, pulse the owner's resp in RESP.
//
// Handshake: each requester holds its request level and inputs stable until
// it sees its one-cycle *_pmem_resp pulse; L2 sees a level read/write strobe
// that stays high, with address and data stable, until its one-cycle l2_resp.
// Requests are only sampled in IDLE; later changes to requester inputs do
// not disturb a transaction that is already in flight.
module l2_port_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int LINE_WIDTH  = 128,
    parameter int OFFSET_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    input  logic                  i_pmem_read,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic [ADDR_WIDTH-1:0] l2_address,
    output logic                  l2_read,
    output logic                  l2_write,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    input  logic                  l2_resp,

    output logic [1:0]            dbg_state,
    output logic                  dbg_last_grant
);

    // Clears the line-offset bits so L2 always sees a line-aligned address.
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

    arb_state_t              state_q, state_d;
    arb_owner_t              owner_q, owner_d;
    arb_owner_t              last_q, last_d;
    arb_owner_t              pick;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    is_write_q, is_write_d;
    logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    req_i, req_d;

    assign req_i = i_pmem_read;
    // Read and write together is illegal; it is treated as a write.
    assign req_d = d_pmem_read | d_pmem_write;

    // Next-state and datapath latch logic for the IDLE/BUSY/RESP sequence.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        rdata_d    = rdata_q;
        pick       = rr_pick2(req_i, req_d, last_q);
        case (state_q)
            IDLE: begin
                // l2_resp is deliberately ignored here (stale after a reset).
                if (req_i || req_d) begin
                    owner_d = pick;
                    last_d  = pick;
                    state_d = BUSY;
                    if (pick == OWN_D) begin
                        addr_d     = d_pmem_address & LINE_MASK;
                        wdata_d    = d_pmem_wdata;
                        is_write_d = d_pmem_write;
                    end else begin
                        addr_d     = i_pmem_address & LINE_MASK;
                        is_write_d = 1'b0;
                    end
                end
            end
            BUSY: begin
                if (l2_resp) begin
                    rdata_d = l2_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset back to an idle, empty arbiter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_I;
            last_q     <= OWN_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            rdata_q    <= rdata_d;
        end
    end

    assign l2_address     = addr_q;
    assign l2_wdata       = wdata_q;
    assign l2_read        = (state_q == BUSY) && !is_write_q;
    assign l2_write       = (state_q == BUSY) &&  is_write_q;
    assign i_pmem_rdata   = rdata_q;
    assign d_pmem_rdata   = rdata_q;
    assign i_pmem_resp    = (state_q == RESP) && (owner_q == OWN_I);
    assign d_pmem_resp    = (state_q == RESP) && (owner_q == OWN_D);
    assign dbg_state      = state_q;
    assign dbg_last_grant = (last_q == OWN_D);

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: the bench plays both L1 requesters and
// the L2 memory, with hand-computed expected addresses, data and pulse timing.
module tb_l2_port_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] i_pmem_address = '0;
    logic          i_pmem_read = 1'b0;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic [AW-1:0] d_pmem_address = '0;
    logic          d_pmem_read = 1'b0;
    logic          d_pmem_write = 1'b0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic [AW-1:0] l2_address;
    logic          l2_read;
    logic          l2_write;
    logic [LW-1:0] l2_wdata;
    logic [LW-1:0] l2_rdata = '0;
    logic          l2_resp = 1'b0;
    logic [1:0]    dbg_state;
    logic          dbg_last_grant;

    int checks = 0;
    int errors = 0;

    l2_port_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .i_pmem_address (i_pmem_address),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_address (d_pmem_address),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .l2_address     (l2_address),
        .l2_read        (l2_read),
        .l2_write       (l2_write),
        .l2_wdata       (l2_wdata),
        .l2_rdata       (l2_rdata),
        .l2_resp        (l2_resp),
        .dbg_state      (dbg_state),
        .dbg_last_grant (dbg_last_grant)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        l2_resp = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Called just after the grant edge (first BUSY cycle). Acts as L2 with
    // `waits` idle BUSY cycles, then checks the RESP cycle and return to IDLE.
    // With drop set, the owner's request is released during the RESP cycle.
    task automatic serve(input string tag, input logic [AW-1:0] addr, input logic wr,
                         input logic [LW-1:0] wdata, input int waits,
                         input logic [LW-1:0] rdata, input logic own_d, input logic drop);
        for (int i = 0; i <= waits; i++) begin
            check({tag, ".state_busy"}, LW'(dbg_state), LW'(S_BUSY));
            check({tag, ".l2_read"},  LW'(l2_read),  LW'(!wr));
            check({tag, ".l2_write"}, LW'(l2_write), LW'(wr));
            check({tag, ".no_overlap"}, LW'(l2_read & l2_write), '0);
            check({tag, ".l2_address"}, LW'(l2_address), LW'(addr));
            if (wr) check({tag, ".l2_wdata"}, l2_wdata, wdata);
            check({tag, ".no_i_resp_busy"}, LW'(i_pmem_resp), '0);
            check({tag, ".no_d_resp_busy"}, LW'(d_pmem_resp), '0);
            if (i == waits) begin
                l2_resp = 1'b1;
                l2_rdata = rdata;
            end
            tick();
            l2_resp = 1'b0;
            l2_rdata = {4{$urandom()}};
        end
        check({tag, ".state_resp"}, LW'(dbg_state), LW'(S_RESP));
        check({tag, ".i_resp"}, LW'(i_pmem_resp), LW'(!own_d));
        check({tag, ".d_resp"}, LW'(d_pmem_resp), LW'(own_d));
        check({tag, ".rdata"}, own_d ? d_pmem_rdata : i_pmem_rdata, rdata);
        check({tag, ".strobes_off"}, LW'({l2_read, l2_write}), '0);
        if (drop) begin
            if (own_d) begin
                d_pmem_read = 1'b0;
                d_pmem_write = 1'b0;
            end else begin
                i_pmem_read = 1'b0;
            end
        end
        tick();
        check({tag, ".state_idle"}, LW'(dbg_state), LW'(S_IDLE));
        check({tag, ".resp_done"}, LW'({i_pmem_resp, d_pmem_resp}), '0);
    endtask

    // Scenario sequence and final report
    initial begin
        logic [LW-1:0] wd;

        // Reset state
        do_reset();
        check("rst.state", LW'(dbg_state), LW'(S_IDLE));
        check("rst.last_grant", LW'(dbg_last_grant), '0);
        check("rst.strobes", LW'({l2_read, l2_write}), '0);
        check("rst.l2_address", LW'(l2_address), '0);
        check("rst.l2_wdata", l2_wdata, '0);
        check("rst.resp", LW'({i_pmem_resp, d_pmem_resp}), '0);
        check("rst.i_rdata", i_pmem_rdata, '0);
        check("rst.d_rdata", d_pmem_rdata, '0);

        // Single I read, two L2 wait cycles
        i_pmem_address = 16'h302A;
        i_pmem_read = 1'b1;
        tick();
        serve("t1", 16'h3020, 1'b0, '0, 2, {16{8'hA5}}, 1'b0, 1'b1);

        // Simultaneous I read and D write right after reset: D first, then I
        do_reset();
        wd = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        i_pmem_address = 16'h1000;
        i_pmem_read = 1'b1;
        d_pmem_address = 16'h2000;
        d_pmem_write = 1'b1;
        d_pmem_wdata = wd;
        tick();
        check("t2.last_d", LW'(dbg_last_grant), LW'(1'b1));
        serve("t2d", 16'h2000, 1'b1, wd, 0, 128'h5, 1'b1, 1'b1);
        tick();
        check("t2.last_i", LW'(dbg_last_grant), LW'(1'b0));
        serve("t2i", 16'h1000, 1'b0, '0, 1, 128'hCAFE_0000_BEEF, 1'b0, 1'b1);

        // Both held for four transactions: D, I, D, I
        do_reset();
        i_pmem_address = 16'h1084;
        i_pmem_read = 1'b1;
        d_pmem_address = 16'h204C;
        d_pmem_read = 1'b1;
        tick();
        check("t3.g1", LW'(dbg_last_grant), LW'(1'b1));
        serve("t3a", 16'h2040, 1'b0, '0, 0, 128'h11, 1'b1, 1'b0);
        tick();
        check("t3.g2", LW'(dbg_last_grant), LW'(1'b0));
        serve("t3b", 16'h1080, 1'b0, '0, 1, 128'h22, 1'b0, 1'b0);
        tick();
        check("t3.g3", LW'(dbg_last_grant), LW'(1'b1));
        serve("t3c", 16'h2040, 1'b0, '0, 0, 128'h33, 1'b1, 1'b0);
        tick();
        check("t3.g4", LW'(dbg_last_grant), LW'(1'b0));
        serve("t3d", 16'h1080, 1'b0, '0, 2, 128'h44, 1'b0, 1'b0);
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;

        // Reset in the second BUSY cycle of a D read; stale l2_resp later
        do_reset();
        d_pmem_address = 16'h5555;
        d_pmem_read = 1'b1;
        tick();
        check("t4.busy1", LW'(l2_read), LW'(1'b1));
        check("t4.addr", LW'(l2_address), LW'(16'h5550));
        tick();
        check("t4.busy2", LW'(l2_read), LW'(1'b1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        d_pmem_read = 1'b0;
        check("t4.strobes_low", LW'({l2_read, l2_write}), '0);
        check("t4.state_idle", LW'(dbg_state), LW'(S_IDLE));
        check("t4.no_resp", LW'(d_pmem_resp), '0);
        tick();
        tick();
        l2_resp = 1'b1;
        l2_rdata = 128'hDEAD;
        tick();
        l2_resp = 1'b0;
        check("t4.stale_state", LW'(dbg_state), LW'(S_IDLE));
        check("t4.stale_strobes", LW'({l2_read, l2_write}), '0);
        check("t4.stale_resp", LW'(d_pmem_resp), '0);
        tick();
        check("t4.stale_resp2", LW'({i_pmem_resp, d_pmem_resp}), '0);
        check("t4.stale_state2", LW'(dbg_state), LW'(S_IDLE));

        // D read and write both high: treated as a write
        do_reset();
        wd = {8{16'h9C3E}};
        d_pmem_address = 16'h40F3;
        d_pmem_read = 1'b1;
        d_pmem_write = 1'b1;
        d_pmem_wdata = wd;
        tick();
        serve("t5", 16'h40F0, 1'b1, wd, 1, 128'h77, 1'b1, 1'b1);

        // I request dropped and changed mid-BUSY: transaction still completes
        i_pmem_address = 16'h777F;
        i_pmem_read = 1'b1;
        tick();
        i_pmem_read = 1'b0;
        i_pmem_address = 16'h0123;
        serve("t6", 16'h7770, 1'b0, '0, 2, {4{32'h600D_F00D}}, 1'b0, 1'b1);
        tick();
        check("t6.no_regrant", LW'(dbg_state), LW'(S_IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L2 cache port between the L1 instruction-cache miss path and the L1 data-cache miss/writeback path of the pipelined LC-3b CPU.
- Grants one requester at a time, latches its line address, op and write data, and drives one L2 transaction to completion.
- Returns the L2 response, registered, to the granted side only.
- On simultaneous requests, alternates grants (round-robin) so neither fetch nor memory stage starves.

Parameters:
ADDR_WIDTH, 16, byte address width
LINE_WIDTH, 128, cache line width in bits (8 words)
OFFSET_BITS, 4, line-offset bits forced to zero on the L2 address

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
i_pmem_address  in  ADDR_WIDTH  I-cache miss line address
i_pmem_read  in  1  I-cache line read request; held until i_pmem_resp
i_pmem_rdata  out  LINE_WIDTH  line returned to I-cache
i_pmem_resp  out  1  one-cycle completion pulse to I-cache
d_pmem_address  in  ADDR_WIDTH  D-cache line address
d_pmem_read  in  1  D-cache line read request
d_pmem_write  in  1  D-cache line writeback request
d_pmem_wdata  in  LINE_WIDTH  writeback line
d_pmem_rdata  out  LINE_WIDTH  line returned to D-cache
d_pmem_resp  out  1  one-cycle completion pulse to D-cache
l2_address  out  ADDR_WIDTH  line-aligned address to L2
l2_read  out  1  L2 read strobe, level, held until l2_resp
l2_write  out  1  L2 write strobe, level, held until l2_resp
l2_wdata  out  LINE_WIDTH  write line to L2
l2_rdata  in  LINE_WIDTH  line from L2, valid with l2_resp
l2_resp  in  1  L2 completion, one cycle

Behaviour:
- States: IDLE, BUSY, RESP. Registers: state, owner (I/D), last_grant, addr_q, wdata_q, is_write_q, rdata_q.
- Reset, in the cycle reset is sampled high:
  - state=IDLE, last_grant=I (first conflict goes to D), owner=I.
  - addr_q, wdata_q, rdata_q, is_write_q cleared.
  - Outputs: l2_read=l2_write=0, l2_address=0, l2_wdata=0, i/d_pmem_resp=0, i/d_pmem_rdata=0.
- IDLE:
  - reqI=i_pmem_read; reqD=d_pmem_read|d_pmem_write.
  - Only one request: grant it.
  - Both: grant the side not equal to last_grant.
  - On grant: latch address with low OFFSET_BITS zeroed; latch wdata and is_write=d_pmem_write (D only); set owner and last_grant; go to BUSY.
  - No request: stay.
  - l2_resp in IDLE is ignored.
- BUSY:
  - l2_read=!is_write_q, l2_write=is_write_q; l2_address=addr_q, l2_wdata=wdata_q, all stable.
  - On l2_resp: capture l2_rdata into rdata_q, go to RESP.
  - No timeout; waits indefinitely.
- RESP (exactly one cycle):
  - Assert owner's *_pmem_resp=1; the other side's resp=0.
  - Both *_pmem_rdata=rdata_q; only the owner's is meaningful.
  - L2 strobes are 0.
  - Always returns to IDLE next cycle.
- Latency: grant at IDLE edge; first L2 strobe the next cycle; requester resp one cycle after l2_resp. Minimum request-to-resp is 3 cycles with a zero-wait L2.
- Requester contract: hold request and inputs stable until resp; drop the request on the cycle after resp. IDLE re-samples in that cycle, so back-to-back requests from the same side are legal.
- Arbiter does not snoop inputs after grant. A request dropped or changed mid-BUSY does not affect the transaction; completion and resp pulse still occur.
- d_pmem_read and d_pmem_write both high is illegal; the arbiter treats it as a write.
- reset during BUSY/RESP: immediate return to IDLE, strobes low, no resp pulse; any later stale l2_resp is ignored.
- Writes also produce a resp pulse. rdata for a write is whatever L2 drove and carries no meaning.

Decomposition:
- Shared package lc3b_types: the lc3b_c_line typedef (LINE_WIDTH vector), an arb_state_t enum {IDLE,BUSY,RESP}, and an arb_owner_t enum {OWN_I,OWN_D}.
- No sub-module needed. Optionally factor the round-robin pick into a small rr_pick2 function, not a module.

Test Plan:
- Reset, then i_pmem_read=1 at addr 16'h302A with L2 resp after 2 wait cycles, l2_rdata=128'hA5...A5:
  - l2_address=16'h3020 and l2_read=1 for 3 cycles.
  - i_pmem_resp pulses once with rdata A5...A5; d_pmem_resp stays 0.
- Simultaneous I read 16'h1000 and D write 16'h2000 right after reset:
  - D served first (l2_write=1, l2_wdata=d wdata).
  - Then I served (l2_read, 16'h1000).
  - Exactly one resp pulse each, in that order.
- Both held continuously for 4 transactions:
  - Grant order D, I, D, I.
  - last_grant alternation verified; no overlap of l2_read and l2_write.
- reset asserted in the second BUSY cycle of a D read, then l2_resp arrives 2 cycles later:
  - Strobes low the cycle after reset; no d_pmem_resp.
  - Stale l2_resp ignored; state IDLE.
- D read and write both high at 16'h40F3: performs write at l2_address 16'h40F0 and pulses d_pmem_resp once.
- I request drops mid-BUSY: transaction still completes, with l2_read held to l2_resp and i_pmem_resp pulsing once.
